ipsxe_floating_point_z_group2_norm_v1_0: RTL and testbench
==========================================================

Name: ipsxe_floating_point_z_group2_norm_v1_0

Overview:
- Downstream consumer of the z*group2 rounding APM in the invsqrt datapath.
- Takes the rounded group2 mantissa word (17 leading zeros already stripped), the matching exponent and the special-case tag.
- Performs carry-out normalisation and final round-to-nearest-even on the RNE guard bits, then exponent adjust/saturation and special-case override.
- Drives a 2-stage valid/ready pipeline into the pack stage.

Parameters:
MAN_WIDTH, 52, IEEE fraction width of the format.
RNE, 2, guard bits carried below the fraction LSB.
EXP_WIDTH, 11, biased exponent width.
IN_W, (MAN_WIDTH+1)+RNE-17 (=38), input word width; derived, do not override.
FRAC_W, IN_W-2-RNE (=34), output fraction width; derived.

Ports:
i_clk  input  1  clock, rising edge.
i_rst_n  input  1  asynchronous active-low reset.
i_valid  input  1  input word valid.
o_ready  output  1  block can accept input this cycle.
i_z_group2_dlt17zeros  input  IN_W  rounded mantissa. Bit IN_W-1 is the carry bit, bit IN_W-2 is the hidden one, then FRAC_W fraction bits, then RNE guard bits.
i_exp  input  EXP_WIDTH  biased exponent, aligned with the mantissa.
i_special  input  2  tag: 00 normal, 01 zero result, 10 infinity, 11 NaN.
o_valid  output  1  output valid.
i_ready  input  1  downstream accepts output.
o_frac  output  FRAC_W  normalised, rounded fraction, hidden bit removed.
o_exp  output  EXP_WIDTH  final biased exponent.
o_ovf  output  1  exponent saturated to infinity for this result.

Behaviour:
Reset and handshake:
- Async reset (i_rst_n=0): both stage valids, o_valid, o_frac, o_exp and o_ovf are 0 immediately.
- Reset mid-operation discards in-flight words; no output appears after release until new input is accepted.
- Input transfer occurs on i_valid&&o_ready. Output transfer occurs on o_valid&&i_ready.
- stall = o_valid&&!i_ready. o_ready = !(s1_valid&&stall), so o_ready=1 whenever stage 1 is empty.
- While stall=1, stage-2 registers hold and outputs stay stable. Stage 1 holds if it is full.
- Latency: 2 cycles from input transfer to o_valid with no stall. Throughput 1 word/cycle.
- Back-to-back words with i_ready held high produce back-to-back outputs in order. No word is ever dropped or duplicated.

Stage 1 (normalise):
- If carry bit =1: shift mantissa right 1, fold the shifted-out bit into sticky, and set exp1 = i_exp+1 (computed EXP_WIDTH+1 wide).
- Otherwise: mantissa unchanged, sticky=0, exp1 = i_exp.
- The special tag is registered alongside.

Stage 2 (round and finish):
- Signals: G = guard MSB; rest = OR(lower guard bits, sticky); L = fraction LSB.
- Round up iff G&&(rest||L). A tie rounds to even.
- If the fraction increment carries out: fraction=0, exponent+1.
- If the final exponent >= 2^EXP_WIDTH-1: o_exp = all ones, o_frac=0, o_ovf=1.
- If the final exponent = 0: o_frac=0, o_exp=0. Flush-to-zero, o_ovf=0.

Special tag (overrides the arithmetic):
- 01: o_frac=0, o_exp=0.
- 10: o_exp = all ones, o_frac=0, o_ovf=0.
- 11: o_exp = all ones, o_frac = MSB 1, others 0 (quiet NaN).

Test Plan:
1. Basic latency: in=38'h10_0000_0000, exp=1023, tag 00, i_ready=1 -> 2 cycles later o_valid=1, o_frac=0, o_exp=1023, o_ovf=0.
2. Rounding:
   - Tie, even LSB: in=38'h10_0000_0002 (G=1, R=0, L=0) -> o_frac=0.
   - Tie, odd LSB: in=38'h10_0000_0006 -> o_frac=2.
   - Below half: in=38'h10_0000_0001 -> o_frac=0.
3. Carry and saturation:
   - Carry normalise: in=38'h20_0000_0000, exp=1000 -> o_frac=0, o_exp=1001.
   - Rounding carry-out: in=38'h1F_FFFF_FFFF, exp=1000 -> o_frac=0, o_exp=1001.
   - Saturation: same input with exp=2046 -> o_exp=2047, o_frac=0, o_ovf=1.
4. Specials: tags 01/10/11 with arbitrary mantissa -> (frac 0, exp 0), (0, 2047), (34'h2_0000_0000, 2047) respectively.
5. Backpressure:
   - Stream 5 words with i_ready=0 from cycle 3 to 6 -> o_ready drops once both stages are full and outputs are held stable.
   - After release, all 5 results appear in order with no loss or duplicate.
6. Reset mid-operation: assert i_rst_n=0 with 2 words in flight -> o_valid=0 asynchronously; after release, no stale output appears and the first new word emerges 2 cycles after acceptance.

Source files
------------

// File: rtl/ipsxe_floating_point_z_group2_norm_v1_0_if.sv
// ipsxe_floating_point_z_group2_norm_v1_0_if: upstream/downstream handshake bundle for the z*group2 normaliser
interface ipsxe_floating_point_z_group2_norm_v1_0_if #(
  parameter int MAN_WIDTH = 52,
  parameter int RNE = 2,
  parameter int EXP_WIDTH = 11
);
  localparam int IN_W = (MAN_WIDTH + 1) + RNE - 17;
  localparam int FRAC_W = IN_W - 2 - RNE;
  logic i_valid;
  logic o_ready;
  logic [IN_W-1:0] i_z_group2_dlt17zeros;
  logic [EXP_WIDTH-1:0] i_exp;
  logic [1:0] i_special;
  logic o_valid;
  logic i_ready;
  logic [FRAC_W-1:0] o_frac;
  logic [EXP_WIDTH-1:0] o_exp;
  logic o_ovf;
  modport slave (
    input i_valid, i_z_group2_dlt17zeros, i_exp, i_special, i_ready,
    output o_ready, o_valid, o_frac, o_exp, o_ovf
  );
  modport master (
    output i_valid, i_z_group2_dlt17zeros, i_exp, i_special, i_ready,
    input o_ready, o_valid, o_frac, o_exp, o_ovf
  );
endinterface

// File: rtl/ipsxe_floating_point_z_group2_norm_v1_0.sv
// ipsxe_floating_point_z_group2_norm_v1_0: carry normalise, RNE round, exponent saturate and special override in a 2-stage pipe
module ipsxe_floating_point_z_group2_norm_v1_0 #(
  parameter int MAN_WIDTH = 52,
  parameter int RNE = 2,
  parameter int EXP_WIDTH = 11
) (
  input logic i_clk,
  input logic i_rst_n,
  ipsxe_floating_point_z_group2_norm_v1_0_if.slave bus
);
  localparam int IN_W = (MAN_WIDTH + 1) + RNE - 17;
  localparam int FRAC_W = IN_W - 2 - RNE;
  localparam logic [EXP_WIDTH:0] EXP_MAX = (EXP_WIDTH+1)'((1 << EXP_WIDTH) - 1);
  logic s1_valid, s1_sticky, stall, carry;
  logic [IN_W-3:0] s1_man;
  logic [EXP_WIDTH:0] s1_exp;
  logic [1:0] s1_special;
  logic [FRAC_W-1:0] frac;
  logic g, rest, up, sat, zero;
  logic [FRAC_W:0] sum;
  logic [EXP_WIDTH:0] exp2;
  logic [FRAC_W-1:0] n_frac;
  logic [EXP_WIDTH-1:0] n_exp;
  logic n_ovf;
  assign stall = bus.o_valid && !bus.i_ready;
  assign bus.o_ready = !(s1_valid && stall);
  assign carry = bus.i_z_group2_dlt17zeros[IN_W-1];
  // the hidden bit is implied after normalisation, so only fraction and guard bits are kept
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      s1_valid <= 1'b0;
      s1_man <= '0;
      s1_sticky <= 1'b0;
      s1_exp <= '0;
      s1_special <= '0;
    end else if (bus.o_ready) begin
      s1_valid <= bus.i_valid;
      if (bus.i_valid) begin
        s1_man <= carry ? bus.i_z_group2_dlt17zeros[IN_W-2:1] : bus.i_z_group2_dlt17zeros[IN_W-3:0];
        s1_sticky <= carry & bus.i_z_group2_dlt17zeros[0];
        s1_exp <= {1'b0, bus.i_exp} + (EXP_WIDTH+1)'(carry);
        s1_special <= bus.i_special;
      end
    end
  assign frac = s1_man[IN_W-3:RNE];
  assign g = s1_man[RNE-1];
  assign rest = (|s1_man[RNE-2:0]) | s1_sticky;
  assign up = g & (rest | frac[0]);
  assign sum = {1'b0, frac} + (FRAC_W+1)'(up);
  assign exp2 = s1_exp + (EXP_WIDTH+1)'(sum[FRAC_W]);
  assign sat = exp2 >= EXP_MAX;
  assign zero = exp2 == '0;
  always_comb begin
    n_frac = sum[FRAC_W-1:0];
    n_exp = exp2[EXP_WIDTH-1:0];
    n_ovf = 1'b0;
    if (s1_special == 2'b01) begin
      n_frac = '0;
      n_exp = '0;
    end else if (s1_special == 2'b10) begin
      n_frac = '0;
      n_exp = '1;
    end else if (s1_special == 2'b11) begin
      n_frac = {1'b1, {(FRAC_W-1){1'b0}}};
      n_exp = '1;
    end else if (sat) begin
      n_frac = '0;
      n_exp = '1;
      n_ovf = 1'b1;
    end else if (zero) begin
      n_frac = '0;
      n_exp = '0;
    end
  end
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      bus.o_valid <= 1'b0;
      bus.o_frac <= '0;
      bus.o_exp <= '0;
      bus.o_ovf <= 1'b0;
    end else if (!stall) begin
      bus.o_valid <= s1_valid;
      if (s1_valid) begin
        bus.o_frac <= n_frac;
        bus.o_exp <= n_exp;
        bus.o_ovf <= n_ovf;
      end
    end
endmodule

// File: tb/tb_ipsxe_floating_point_z_group2_norm_v1_0.sv
// tb_ipsxe_floating_point_z_group2_norm_v1_0: directed vectors checked against an arithmetic rounding model and literals
module tb_ipsxe_floating_point_z_group2_norm_v1_0;
  typedef struct packed {
    logic [33:0] frac;
    logic [10:0] exp;
    logic ovf;
  } res_t;
  typedef struct {
    res_t m;
    bit lit;
    res_t l;
    bit lat;
    int acc;
  } ent_t;
  logic clk, rst_n;
  int cyc = 0, n_checks = 0, n_fail = 0;
  ent_t q[$];
  bit cur_lit, cur_lat;
  res_t cur_l;
  bit stall_prev = 0;
  res_t prev_out;
  ipsxe_floating_point_z_group2_norm_v1_0_if bus ();
  ipsxe_floating_point_z_group2_norm_v1_0 dut (.i_clk(clk), .i_rst_n(rst_n), .bus(bus));
  initial clk = 0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc = cyc + 1;
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] want);
    n_checks++;
    if (act !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, want);
    end
  endtask
  // value-level model: keep the integer part above the guard position, round by comparing the remainder with half
  function automatic res_t model(input logic [37:0] m, input logic [10:0] e, input logic [1:0] t);
    longint unsigned v, kept, rem, half;
    int sh, ex;
    res_t r;
    sh = m[37] ? 3 : 2;
    v = m;
    kept = v >> sh;
    rem = v & ((64'd1 << sh) - 1);
    half = 64'd1 << (sh - 1);
    if (rem > half || (rem == half && kept[0])) kept++;
    ex = int'(e) + (m[37] ? 1 : 0);
    if (kept >= (64'd1 << 35)) begin
      kept >>= 1;
      ex++;
    end
    r.frac = kept[33:0];
    r.exp = ex[10:0];
    r.ovf = 1'b0;
    if (t == 2'b01) r = '0;
    else if (t == 2'b10) r = {34'd0, 11'h7ff, 1'b0};
    else if (t == 2'b11) r = {34'h2_0000_0000, 11'h7ff, 1'b0};
    else if (ex >= 2047) r = {34'd0, 11'h7ff, 1'b1};
    else if (ex == 0) r = '0;
    return r;
  endfunction
  always @(negedge clk) begin
    if (rst_n) begin
      if (stall_prev && bus.o_valid) chk("stall_hold", {bus.o_frac, bus.o_exp, bus.o_ovf}, prev_out);
      if (bus.o_valid && bus.i_ready) begin
        if (q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_output: got frac=%0h exp=%0d with no word pending", bus.o_frac, bus.o_exp);
        end else begin
          ent_t e;
          e = q.pop_front();
          chk("model_frac", bus.o_frac, e.m.frac);
          chk("model_exp", bus.o_exp, e.m.exp);
          chk("model_ovf", bus.o_ovf, e.m.ovf);
          if (e.lit) chk("literal_result", {bus.o_frac, bus.o_exp, bus.o_ovf}, e.l);
          if (e.lat) chk("latency", cyc - e.acc, 2);
        end
      end
      if (bus.i_valid && bus.o_ready)
        q.push_back('{model(bus.i_z_group2_dlt17zeros, bus.i_exp, bus.i_special), cur_lit, cur_l, cur_lat, cyc});
      stall_prev = bus.o_valid && !bus.i_ready;
      prev_out = {bus.o_frac, bus.o_exp, bus.o_ovf};
    end else stall_prev = 0;
  end
  task automatic send(input logic [37:0] m, input logic [10:0] e, input logic [1:0] t, input bit lit,
                      input logic [33:0] lf, input logic [10:0] le, input logic lo, input bit lat);
    int n;
    bus.i_z_group2_dlt17zeros = m;
    bus.i_exp = e;
    bus.i_special = t;
    bus.i_valid = 1'b1;
    cur_lit = lit;
    cur_l = {lf, le, lo};
    cur_lat = lat;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.o_ready && n < 50);
    if (!bus.o_ready) chk("accept_timeout", 0, 1);
    @(posedge clk);
    #1;
  endtask
  task automatic drain();
    bus.i_valid = 1'b0;
    for (int i = 0; i < 20 && q.size() != 0; i++) begin
      @(posedge clk);
      #1;
    end
    chk("drain_empty", q.size(), 0);
  endtask
  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end
  initial begin
    rst_n = 0;
    bus.i_valid = 0;
    bus.i_ready = 1;
    bus.i_z_group2_dlt17zeros = '0;
    bus.i_exp = '0;
    bus.i_special = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_o_valid", bus.o_valid, 0);
    chk("reset_o_frac", bus.o_frac, 0);
    chk("reset_o_exp", bus.o_exp, 0);
    chk("reset_o_ovf", bus.o_ovf, 0);
    chk("reset_o_ready", bus.o_ready, 1);
    rst_n = 1;
    @(posedge clk);
    #1;
    send(38'h10_0000_0000, 11'd1023, 2'b00, 1, 34'd0, 11'd1023, 0, 1);
    drain();
    send(38'h10_0000_0002, 11'd1023, 2'b00, 1, 34'd0, 11'd1023, 0, 0);
    send(38'h10_0000_0006, 11'd1023, 2'b00, 1, 34'd2, 11'd1023, 0, 0);
    send(38'h10_0000_0001, 11'd1023, 2'b00, 1, 34'd0, 11'd1023, 0, 0);
    send(38'h20_0000_0000, 11'd1000, 2'b00, 1, 34'd0, 11'd1001, 0, 0);
    send(38'h1F_FFFF_FFFF, 11'd1000, 2'b00, 1, 34'd0, 11'd1001, 0, 0);
    send(38'h1F_FFFF_FFFF, 11'd2046, 2'b00, 1, 34'd0, 11'd2047, 1, 0);
    send(38'h15_5555_5555, 11'd500, 2'b01, 1, 34'd0, 11'd0, 0, 0);
    send(38'h15_5555_5555, 11'd500, 2'b10, 1, 34'd0, 11'd2047, 0, 0);
    send(38'h15_5555_5555, 11'd500, 2'b11, 1, 34'h2_0000_0000, 11'd2047, 0, 0);
    send(38'h10_0000_0003, 11'd0, 2'b00, 1, 34'd0, 11'd0, 0, 0);
    send(38'h3F_FFFF_FFFF, 11'd2046, 2'b00, 1, 34'd0, 11'd2047, 1, 0);
    send(38'h10_0000_0007, 11'd5, 2'b00, 1, 34'd2, 11'd5, 0, 0);
    send(38'h2A_AAAA_AAAB, 11'd77, 2'b00, 0, 34'd0, 11'd0, 0, 0);
    drain();
    fork
      begin
        for (int i = 0; i < 5; i++)
          send(38'h10_0000_0000 | 38'(i * 37 + 5), 11'(100 + i), 2'b00, 0, 34'd0, 11'd0, 0, 0);
        bus.i_valid = 1'b0;
      end
      begin
        repeat (3) @(posedge clk);
        #1;
        bus.i_ready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("o_ready_backpressure", bus.o_ready, 0);
        @(posedge clk);
        #1;
        bus.i_ready = 1'b1;
      end
    join
    drain();
    send(38'h10_0000_0004, 11'd300, 2'b00, 0, 34'd0, 11'd0, 0, 0);
    send(38'h20_0000_0004, 11'd301, 2'b00, 0, 34'd0, 11'd0, 0, 0);
    bus.i_valid = 1'b0;
    rst_n = 0;
    #1;
    chk("async_reset_o_valid", bus.o_valid, 0);
    chk("async_reset_o_frac", bus.o_frac, 0);
    chk("async_reset_o_exp", bus.o_exp, 0);
    q.delete();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1;
    repeat (3) @(posedge clk);
    #1;
    chk("post_reset_idle", bus.o_valid, 0);
    send(38'h10_0000_0006, 11'd1023, 2'b00, 1, 34'd2, 11'd1023, 0, 1);
    drain();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
